bcd_seq_conv: RTL and testbench
===============================

// Module: bcd_seq_conv
// PURPOSE
//  Parametrised, sequential binary-to-BCD converter using iterative double-dabble, one bit per clock.
//  Replaces the fixed 8-bit combinational converter for wider counters and sensor values on the 7-segment / SPI display path.
//  Start/done handshake, held result, leading-zero blanking mask, overflow flag.
//  Sits between the value source (SPI receive registers, counters) and the display formatter.
// PARAMETERS
//  BIN_W   16  binary input width, 2..32
//  DIGITS  5   BCD digits produced; ceil(BIN_W*log10(2)) gives exact coverage
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           request conversion of binary; sampled when not busy
//  binary     in   BIN_W       unsigned value, captured on accepted start
//  busy       out  1           conversion in progress
//  done       out  1           one-cycle pulse: bcd_out/digit_en/overflow updated
//  bcd_out    out  4*DIGITS    packed BCD, digit 0 (ones) in [3:0]
//  digit_en   out  DIGITS      1 = digit displayed (leading-zero blanking)
//  overflow   out  1           value did not fit in DIGITS digits
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, bcd_out=0, digit_en={{DIGITS-1{0}},1}, overflow=0.
//  Reset mid-conversion: abort, return to IDLE, outputs take reset values; no done pulse.
//  States: IDLE -> SHIFT -> DONE -> (IDLE | SHIFT).
//   IDLE/DONE + start=1 at edge N: capture binary into shift reg, clear digit regs and ovf sticky, cnt=0, busy=1, done=0 -> SHIFT.
//   SHIFT: each edge: per digit, if >=5 add 3 (4-bit); then shift {digits,shreg} left by 1, MSB of shreg into digit 0 bit 0; cnt++.
//    1 leaving digit DIGITS-1 bit 3 sets ovf sticky.
//   At edge N+BIN_W: last shift completes; register bcd_out, digit_en, overflow; busy=0, done=1 -> DONE.
//   DONE: done=1 for exactly one cycle; without start -> IDLE, done=0. Outputs hold until next done.
//  Latency: start at edge N -> done high in the cycle after edge N+BIN_W (BIN_W cycles). Throughput: 1 per BIN_W+1 cycles;
//   start in DONE allows back-to-back results at BIN_W+1 spacing.
//  start while busy: ignored, not queued; binary may change freely while busy.
//  digit_en[k]=1 iff some digit j>=k is nonzero, or k==0. Value 0 -> bcd_out=0, digit_en=...0001.
//  overflow=1: bcd_out holds low DIGITS digits of the true value (mod 10^DIGITS); digit_en computed on those digits.
//  Digits always 0..9 after done; no X on outputs after reset.
// STRUCTURE
//  bcd_pkg: state enum (IDLE, SHIFT, DONE); function digits_for(width) for sizing checks;
//   constant BCD_ADJ_THRESH=4'd5.
//  Sub-module bcd_add3_digit: 4-bit comb. (d>=5 ? d+3 : d), instantiated DIGITS times via generate.
//  Counter width $clog2(BIN_W+1). Elaboration error if BIN_W<2 or DIGITS<1.
// TESTING
//  rst, BIN_W=16/DIGITS=5, start with binary=16'd0 -> done after 16 cycles, bcd_out=20'h00000, digit_en=5'b00001, overflow=0.
//  binary=16'hFFFF -> bcd_out=20'h65535, digit_en=5'b11111, overflow=0; busy high exactly 16 cycles.
//  binary=16'd907, then start held in DONE with 16'd42 -> results 20'h00907 (digit_en 00111) then 20'h00042 (00011), spaced 17 cycles.
//  DIGITS=3, binary=16'd1234 -> bcd_out=12'h234, overflow=1, digit_en=3'b111.
//  start pulses during busy, binary toggled -> no extra done; result is value captured at first start.
//  rst asserted at cycle 8 of conversion -> next cycle busy=0, done never pulses, outputs at reset values; new start converts correctly.
//  Random: 1000 values at BIN_W=8,16,32 vs. reference model; check digits<=9, latency, single-cycle done.

Source files
------------

// File: rtl/bcd_seq_conv_pkg.sv
// bcd_pkg: shared state encoding, adjust threshold and digit-count helper for bcd_seq_conv
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   function automatic int digits_for(input int width);
      longint unsigned v;
      int n;
      v = (64'd1 << width) - 64'd1;
      n = 0;
      while (v != 64'd0) begin
         v = v / 64'd10;
         n++;
      end
      return n < 1 ? 1 : n;
   endfunction
endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble pre-shift correction of one BCD digit
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = d >= BCD_ADJ_THRESH ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential double-dabble binary-to-BCD converter, one bit per clock
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  overflow
);
   localparam int CW = $clog2(BIN_W + 1);
   state_t state, state_nx;
   logic [BIN_W-1:0] sh;
   logic [4*DIGITS-1:0] dig, adj, dig_nx;
   logic [DIGITS-1:0] en_nx;
   logic [CW-1:0] cnt;
   logic ovf, ovf_nx, last;
   if (BIN_W < 2 || BIN_W > 32 || DIGITS < 1) begin : g_bad
      $error("bcd_seq_conv: BIN_W must be 2..32 and DIGITS >= 1");
   end
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bcd_add3_digit u_adj (.d(dig[4*i +: 4]), .q(adj[4*i +: 4]));
      // a digit is shown when it or any more significant digit is nonzero
      assign en_nx[i] = (i == 0) || ((dig_nx >> (4*i)) != '0);
   end
   assign dig_nx = {adj[4*DIGITS-2:0], sh[BIN_W-1]};
   assign ovf_nx = ovf | adj[4*DIGITS-1];
   assign last   = cnt == CW'(BIN_W - 1);
   assign busy   = state == SHIFT;
   assign done   = state == DONE;
   always_comb begin
      state_nx = state == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh       <= '0;
         dig      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         bcd_out  <= '0;
         digit_en <= DIGITS'(1);
         overflow <= 1'b0;
      end else if (state == SHIFT) begin
         sh  <= sh << 1;
         dig <= dig_nx;
         cnt <= cnt + 1'b1;
         ovf <= ovf_nx;
         if (last) begin
            bcd_out  <= dig_nx;
            digit_en <= en_nx;
            overflow <= ovf_nx;
         end
      end else if (start) begin
         sh  <= binary;
         dig <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: directed and model-checked stimulus for bcd_seq_conv at several widths
module tb_bcd_seq_conv;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] st = '0;
   logic [31:0] bin = '0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2, busy3, done3, ovf3;
   logic [19:0] bcd0;
   logic [11:0] bcd1, bcd2;
   logic [39:0] bcd3;
   logic [4:0] en0;
   logic [2:0] en1, en2;
   logic [9:0] en3;
   logic c_busy, c_done, c_ovf;
   logic [39:0] c_bcd;
   logic [9:0] c_en;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd_seq_conv #(.BIN_W(16), .DIGITS(5)) u0 (.clk(clk), .rst(rst), .start(st[0]), .binary(bin[15:0]),
      .busy(busy0), .done(done0), .bcd_out(bcd0), .digit_en(en0), .overflow(ovf0));
   bcd_seq_conv #(.BIN_W(16), .DIGITS(3)) u1 (.clk(clk), .rst(rst), .start(st[1]), .binary(bin[15:0]),
      .busy(busy1), .done(done1), .bcd_out(bcd1), .digit_en(en1), .overflow(ovf1));
   bcd_seq_conv #(.BIN_W(8), .DIGITS(3)) u2 (.clk(clk), .rst(rst), .start(st[2]), .binary(bin[7:0]),
      .busy(busy2), .done(done2), .bcd_out(bcd2), .digit_en(en2), .overflow(ovf2));
   bcd_seq_conv #(.BIN_W(32), .DIGITS(10)) u3 (.clk(clk), .rst(rst), .start(st[3]), .binary(bin),
      .busy(busy3), .done(done3), .bcd_out(bcd3), .digit_en(en3), .overflow(ovf3));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sample(input int i);
      case (i)
         0:       begin c_busy = busy0; c_done = done0; c_ovf = ovf0; c_bcd = 40'(bcd0); c_en = 10'(en0); end
         1:       begin c_busy = busy1; c_done = done1; c_ovf = ovf1; c_bcd = 40'(bcd1); c_en = 10'(en1); end
         2:       begin c_busy = busy2; c_done = done2; c_ovf = ovf2; c_bcd = 40'(bcd2); c_en = 10'(en2); end
         default: begin c_busy = busy3; c_done = done3; c_ovf = ovf3; c_bcd = bcd3; c_en = en3; end
      endcase
   endtask

   function automatic logic [39:0] ref_bcd(input longint unsigned v, input int d);
      logic [39:0] r;
      r = '0;
      for (int k = 0; k < d; k++) begin
         r[4*k +: 4] = 4'(v % 64'd10);
         v = v / 64'd10;
      end
      return r;
   endfunction

   function automatic logic [9:0] ref_en(input logic [39:0] b);
      logic [9:0] e;
      for (int k = 0; k < 10; k++) e[k] = (k == 0) || ((b >> (4*k)) != 40'd0);
      return e;
   endfunction

   function automatic logic ref_ovf(input longint unsigned v, input int d);
      longint unsigned p;
      p = 64'd1;
      repeat (d) p = p * 64'd10;
      return v >= p;
   endfunction

   function automatic logic all_le9(input logic [39:0] b);
      for (int k = 0; k < 10; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   task automatic kick(input int i, input logic [31:0] v);
      bin = v;
      st[i] = 1'b1;
      @(negedge clk);
      st[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, output int bc, output int t);
      bc = 0;
      t = -1;
      for (int n = 0; n < 48; n++) begin
         sample(i);
         if (c_done) begin
            t = cyc;
            break;
         end
         if (c_busy) bc++;
         @(negedge clk);
      end
      chk("done_seen", 64'(c_done), 64'd1);
   endtask

   task automatic conv_check(input int i, input logic [31:0] v, input int w, input int d, input string tag);
      int bc, t;
      logic [39:0] eb;
      kick(i, v);
      wait_done(i, bc, t);
      eb = ref_bcd(64'(v), d);
      chk({tag, "_bcd"}, 64'(c_bcd), 64'(eb));
      chk({tag, "_en"}, 64'(c_en), 64'(ref_en(eb)));
      chk({tag, "_ovf"}, 64'(c_ovf), 64'(ref_ovf(64'(v), d)));
      chk({tag, "_le9"}, 64'(all_le9(c_bcd)), 64'd1);
      chk({tag, "_busy_cycles"}, 64'(bc), 64'(w));
      @(negedge clk);
      sample(i);
      chk({tag, "_done_one_cycle"}, 64'(c_done), 64'd0);
   endtask

   initial begin
      int bc, t1, t2, nd;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sample(i);
         chk("rst_busy", 64'(c_busy), 64'd0);
         chk("rst_done", 64'(c_done), 64'd0);
         chk("rst_bcd", 64'(c_bcd), 64'd0);
         chk("rst_en", 64'(c_en), 64'd1);
         chk("rst_ovf", 64'(c_ovf), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      conv_check(0, 32'd0, 16, 5, "zero");
      chk("zero_bcd_lit", 64'(c_bcd), 64'h00000);
      chk("zero_en_lit", 64'(c_en), 64'b00001);
      conv_check(0, 32'hFFFF, 16, 5, "ffff");
      chk("ffff_bcd_lit", 64'(c_bcd), 64'h65535);
      chk("ffff_en_lit", 64'(c_en), 64'b11111);
      kick(0, 32'd907);
      wait_done(0, bc, t1);
      chk("b2b_907_bcd", 64'(c_bcd), 64'h00907);
      chk("b2b_907_en", 64'(c_en), 64'b00111);
      kick(0, 32'd42);
      wait_done(0, bc, t2);
      chk("b2b_42_bcd", 64'(c_bcd), 64'h00042);
      chk("b2b_42_en", 64'(c_en), 64'b00011);
      chk("b2b_spacing", 64'(t2 - t1), 64'd17);
      @(negedge clk);
      conv_check(1, 32'd1234, 16, 3, "d3_1234");
      chk("d3_1234_bcd_lit", 64'(c_bcd), 64'h234);
      chk("d3_1234_ovf_lit", 64'(c_ovf), 64'd1);
      chk("d3_1234_en_lit", 64'(c_en), 64'b111);
      conv_check(2, 32'd255, 8, 3, "w8_max");
      chk("w8_max_lit", 64'(c_bcd), 64'h255);
      conv_check(3, 32'hFFFF_FFFF, 32, 10, "w32_max");
      chk("w32_max_lit", 64'(c_bcd), 64'h42_9496_7295);
      kick(0, 32'd500);
      for (int n = 0; n < 4; n++) begin
         bin = $urandom;
         st[0] = 1'b1;
         @(negedge clk);
         st[0] = 1'b0;
         bin = $urandom;
         @(negedge clk);
      end
      wait_done(0, bc, t1);
      chk("ign_bcd", 64'(c_bcd), 64'h00500);
      chk("ign_en", 64'(c_en), 64'b00111);
      nd = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         sample(0);
         if (c_done) nd++;
      end
      chk("ign_no_extra_done", 64'(nd), 64'd0);
      kick(0, 32'd12345);
      repeat (7) @(negedge clk);
      sample(0);
      chk("mid_busy_before_rst", 64'(c_busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sample(0);
      chk("mid_rst_busy", 64'(c_busy), 64'd0);
      chk("mid_rst_done", 64'(c_done), 64'd0);
      chk("mid_rst_bcd", 64'(c_bcd), 64'd0);
      chk("mid_rst_en", 64'(c_en), 64'd1);
      chk("mid_rst_ovf", 64'(c_ovf), 64'd0);
      nd = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         sample(0);
         if (c_done) nd++;
      end
      chk("mid_rst_no_done", 64'(nd), 64'd0);
      conv_check(0, 32'd12345, 16, 5, "after_rst");
      chk("after_rst_lit", 64'(c_bcd), 64'h12345);
      for (int n = 0; n < 1000; n++) conv_check(2, $urandom & 32'hFF, 8, 3, "rnd8");
      for (int n = 0; n < 1000; n++) conv_check(0, $urandom & 32'hFFFF, 16, 5, "rnd16");
      for (int n = 0; n < 1000; n++) conv_check(3, $urandom, 32, 10, "rnd32");
      for (int n = 0; n < 100; n++) conv_check(1, $urandom & 32'hFFFF, 16, 3, "rnd16d3");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
